// File: rtl/alu_defs.sv
// alu_defs: ALU op encodings and slice width shared by the execute stage.
package alu_defs;
  localparam int SLICE_W = 4;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  localparam logic [2:0] ALU_ANDN = 3'b100;
  localparam logic [2:0] ALU_ORN  = 3'b101;
endpackage

// File: rtl/cla_carry_unit.sv
// cla_carry_unit: per-slice carry-ins from slice generate/propagate and c0.
module cla_carry_unit #(
  parameter int N = 8
) (
  input  logic [N-1:0] g_i,
  input  logic [N-1:0] p_i,
  input  logic         c0_i,
  output logic [N-1:0] c_o
);
  logic carry;
  always_comb begin
    c_o = '0;
    carry = c0_i;
    for (int k = 0; k < N; k++) begin
      c_o[k] = carry;
      carry = g_i[k] | (p_i[k] & carry);
    end
  end
endmodule

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: sliced ALU with lookahead carries, SLT/overflow/trap logic,
// registered into the EX/MEM pipeline register with stall and flush.
module ex_alu_stage
  import alu_defs::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [WIDTH-1:0]  id_a,
  input  logic [WIDTH-1:0]  id_b,
  input  logic [2:0]        id_op,
  input  logic [WIDTH-1:0]  id_store_data,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_trap_ovf,
  input  logic              ex_stall,
  input  logic              ex_flush,
  output logic              ex_valid,
  output logic [WIDTH-1:0]  ex_result,
  output logic              ex_zero,
  output logic              ex_overflow,
  output logic              ex_ovf_exc,
  output logic [WIDTH-1:0]  ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write
);
  localparam int N = WIDTH / SLICE_W;

  logic [N-1:0]      slice_g, slice_p, slice_cin;
  logic [WIDTH-1:0]  slice_res;
  logic              set_msb, ovf_msb;

  cla_carry_unit #(.N(N)) u_cla (
    .g_i (slice_g),
    .p_i (slice_p),
    .c0_i(id_op[2]),
    .c_o (slice_cin)
  );

  for (genvar k = 0; k < N; k++) begin : g_slice
    logic [3:0] a4, b4, gv, pv, s4;
    logic       carry;
    assign a4 = id_a[SLICE_W*k +: SLICE_W];
    assign b4 = id_b[SLICE_W*k +: SLICE_W] ^ {SLICE_W{id_op[2]}};
    assign gv = a4 & b4;
    assign pv = a4 ^ b4;
    assign slice_g[k] = gv[3] | (pv[3] & (gv[2] | (pv[2] & (gv[1] | (pv[1] & gv[0])))));
    assign slice_p[k] = &pv;
    always_comb begin
      s4 = '0;
      carry = slice_cin[k];
      for (int i = 0; i < SLICE_W; i++) begin
        s4[i] = pv[i] ^ carry;
        carry = gv[i] | (pv[i] & carry);
      end
    end
    assign slice_res[SLICE_W*k +: SLICE_W] = (id_op[1:0] == 2'b00) ? gv :
                                             (id_op[1:0] == 2'b01) ? (a4 | b4) :
                                             (id_op[1:0] == 2'b10) ? s4 : 4'b0000;
    if (k == N - 1) begin : g_msb
      assign set_msb = s4[3];
      assign ovf_msb = (a4[3] == b4[3]) & (s4[3] != a4[3]);
    end
  end

  logic [WIDTH-1:0] result_d;
  logic             ovf_d, exc_d;

  // SLT compares the true sign: raw sign bit corrected by signed overflow
  assign result_d = (id_op == ALU_SLT) ? {{(WIDTH-1){1'b0}}, set_msb ^ ovf_msb} : slice_res;
  assign ovf_d    = ((id_op == ALU_ADD) || (id_op == ALU_SUB)) & ovf_msb;
  assign exc_d    = id_valid & id_trap_ovf & ovf_d;

  logic              valid_q, zero_q, ovf_q, exc_q, rw_q, mr_q, mw_q;
  logic [WIDTH-1:0]  result_q, store_q;
  logic [REG_AW-1:0] rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      exc_q    <= 1'b0;
      store_q  <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
    end else if (ex_flush) begin
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
    end else if (!ex_stall) begin
      valid_q  <= id_valid;
      result_q <= result_d;
      zero_q   <= (result_d == '0);
      ovf_q    <= ovf_d;
      exc_q    <= exc_d;
      store_q  <= id_store_data;
      rd_q     <= id_rd;
      rw_q     <= id_valid & id_reg_write & ~exc_d;
      mr_q     <= id_valid & id_mem_read & ~exc_d;
      mw_q     <= id_valid & id_mem_write & ~exc_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_result     = result_q;
  assign ex_zero       = zero_q;
  assign ex_overflow   = ovf_q;
  assign ex_ovf_exc    = exc_q;
  assign ex_store_data = store_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = rw_q;
  assign ex_mem_read   = mr_q;
  assign ex_mem_write  = mw_q;
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: directed vectors with hand-computed expectations for ex_alu_stage.
module tb_ex_alu_stage;
  import alu_defs::*;

  logic        clk, rst_n;
  logic        id_valid, id_reg_write, id_mem_read, id_mem_write, id_trap_ovf;
  logic [31:0] id_a, id_b, id_store_data;
  logic [2:0]  id_op;
  logic [4:0]  id_rd;
  logic        ex_stall, ex_flush;
  logic        ex_valid, ex_zero, ex_overflow, ex_ovf_exc, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] ex_result, ex_store_data;
  logic [4:0]  ex_rd;

  int tests = 0;
  int fails = 0;

  ex_alu_stage #(.WIDTH(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_a(id_a), .id_b(id_b), .id_op(id_op),
    .id_store_data(id_store_data), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_trap_ovf(id_trap_ovf),
    .ex_stall(ex_stall), .ex_flush(ex_flush), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_zero(ex_zero), .ex_overflow(ex_overflow), .ex_ovf_exc(ex_ovf_exc),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic trap, input logic rw);
    id_valid = v;
    id_op = op;
    id_a = a;
    id_b = b;
    id_trap_ovf = trap;
    id_reg_write = rw;
    id_mem_read = 1'b0;
    id_mem_write = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_stall = 1'b0;
    ex_flush = 1'b0;
    id_store_data = 32'h0;
    id_rd = 5'd0;
    drive(1'b1, ALU_ADD, 32'h1, 32'h1, 1'b0, 1'b1);
    #12;
    check("rst_valid", {31'b0, ex_valid}, 32'h0);
    check("rst_result", ex_result, 32'h0);
    check("rst_zero", {31'b0, ex_zero}, 32'h0);
    rst_n = 1'b1;

    drive(1'b1, ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b1);
    id_rd = 5'd9;
    step();
    check("add_ovf_res", ex_result, 32'h80000000);
    check("add_ovf_flag", {31'b0, ex_overflow}, 32'h1);
    check("add_ovf_exc", {31'b0, ex_ovf_exc}, 32'h1);
    check("add_ovf_rw", {31'b0, ex_reg_write}, 32'h0);
    check("add_ovf_valid", {31'b0, ex_valid}, 32'h1);
    check("add_ovf_rd", {27'b0, ex_rd}, 32'd9);

    drive(1'b1, ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1);
    step();
    check("addu_exc", {31'b0, ex_ovf_exc}, 32'h0);
    check("addu_rw", {31'b0, ex_reg_write}, 32'h1);

    drive(1'b1, ALU_SLT, 32'hFFFFFFFB, 32'h00000003, 1'b0, 1'b1);
    step();
    check("slt_neg", ex_result, 32'h1);
    check("slt_neg_zero", {31'b0, ex_zero}, 32'h0);

    drive(1'b1, ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1);
    step();
    check("slt_ovf", ex_result, 32'h1);
    check("slt_ovf_flag", {31'b0, ex_overflow}, 32'h0);
    check("slt_ovf_exc", {31'b0, ex_ovf_exc}, 32'h0);

    drive(1'b1, ALU_SLT, 32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1);
    step();
    check("slt_swap", ex_result, 32'h0);
    check("slt_swap_zero", {31'b0, ex_zero}, 32'h1);

    drive(1'b1, ALU_SUB, 32'h12345678, 32'h12345678, 1'b1, 1'b1);
    step();
    check("sub_eq_res", ex_result, 32'h0);
    check("sub_eq_zero", {31'b0, ex_zero}, 32'h1);
    check("sub_eq_ovf", {31'b0, ex_overflow}, 32'h0);

    drive(1'b1, ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1);
    step();
    check("add_wrap_res", ex_result, 32'h0);
    check("add_wrap_ovf", {31'b0, ex_overflow}, 32'h0);
    check("add_wrap_rw", {31'b0, ex_reg_write}, 32'h1);

    drive(1'b1, ALU_SUB, 32'h80000000, 32'h00000001, 1'b1, 1'b1);
    step();
    check("sub_ovf_res", ex_result, 32'h7FFFFFFF);
    check("sub_ovf_exc", {31'b0, ex_ovf_exc}, 32'h1);

    drive(1'b1, ALU_ANDN, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 1'b1);
    step();
    check("andn", ex_result, 32'hF000F000);

    drive(1'b1, ALU_ORN, 32'h00000000, 32'hFFFF0000, 1'b0, 1'b1);
    step();
    check("orn", ex_result, 32'h0000FFFF);

    drive(1'b1, ALU_OR, 32'h12340000, 32'h00005678, 1'b0, 1'b1);
    step();
    check("or", ex_result, 32'h12345678);

    drive(1'b1, 3'b011, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1);
    step();
    check("rsvd_res", ex_result, 32'h0);
    check("rsvd_ovf", {31'b0, ex_overflow}, 32'h0);
    check("rsvd_zero", {31'b0, ex_zero}, 32'h1);

    drive(1'b0, ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b1);
    id_mem_read = 1'b1;
    step();
    check("bubble_valid", {31'b0, ex_valid}, 32'h0);
    check("bubble_mr", {31'b0, ex_mem_read}, 32'h0);
    check("bubble_exc", {31'b0, ex_ovf_exc}, 32'h0);
    check("bubble_ovf", {31'b0, ex_overflow}, 32'h1);

    drive(1'b1, ALU_AND, 32'hFFFF0000, 32'h0F0F1234, 1'b0, 1'b1);
    step();
    check("and_res", ex_result, 32'h0F0F0000);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, ALU_ADD, 32'h1 + i, 32'h1, 1'b0, 1'b0);
      step();
      check("stall_res", ex_result, 32'h0F0F0000);
      check("stall_valid", {31'b0, ex_valid}, 32'h1);
    end
    drive(1'b1, ALU_ADD, 32'h1, 32'h1, 1'b0, 1'b1);
    ex_stall = 1'b0;
    step();
    check("unstall_res", ex_result, 32'h2);

    drive(1'b1, ALU_ADD, 32'h100, 32'h4, 1'b0, 1'b0);
    id_mem_write = 1'b1;
    id_store_data = 32'hDEADBEEF;
    step();
    check("store_mw", {31'b0, ex_mem_write}, 32'h1);
    check("store_data", ex_store_data, 32'hDEADBEEF);
    check("store_addr", ex_result, 32'h104);
    ex_stall = 1'b1;
    ex_flush = 1'b1;
    step();
    check("flush_valid", {31'b0, ex_valid}, 32'h0);
    check("flush_mw", {31'b0, ex_mem_write}, 32'h0);
    ex_stall = 1'b0;
    ex_flush = 1'b0;

    drive(1'b1, ALU_ADD, 32'h5, 32'h6, 1'b0, 1'b1);
    step();
    check("pre_rst_res", ex_result, 32'hB);
    check("pre_rst_valid", {31'b0, ex_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, ex_valid}, 32'h0);
    check("async_rst_res", ex_result, 32'h0);
    check("async_rst_rw", {31'b0, ex_reg_write}, 32'h0);
    check("async_rst_store", ex_store_data, 32'h0);
    #1 rst_n = 1'b1;
    #1;
    check("post_rst_hold", ex_result, 32'h0);
    step();
    check("post_rst_res", ex_result, 32'hB);
    check("post_rst_valid", {31'b0, ex_valid}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ex_alu_stage.md
Name: ex_alu_stage

Overview:
- Execute stage of the five-stage MIPS pipeline.
- Builds a WIDTH-bit ALU from WIDTH/4 four-bit ALU slices plus a carry-lookahead unit, and adds SLT, zero and overflow logic.
- Registers the outcome into the EX/MEM pipeline register with valid, stall and flush control.
- Consumes ID/EX operands and control; feeds the MEM stage and the forwarding network.

Parameters:
WIDTH, 32, datapath width; must be a multiple of 4
REG_AW, 5, destination register index width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID/EX holds a live instruction
id_a  input  WIDTH  operand A (rs or forwarded)
id_b  input  WIDTH  operand B (rt, immediate or forwarded)
id_op  input  3  ALU op; bit2 = binv/carry-in, bits1:0 = function
id_store_data  input  WIDTH  rt value passed through for stores
id_rd  input  REG_AW  destination register
id_reg_write  input  1  writes register file
id_mem_read  input  1  load
id_mem_write  input  1  store
id_trap_ovf  input  1  signed overflow traps (add/sub, not addu/subu)
ex_stall  input  1  hold EX/MEM register
ex_flush  input  1  squash the instruction being captured
ex_valid  output  1  EX/MEM holds a live instruction
ex_result  output  WIDTH  ALU result
ex_zero  output  1  ex_result == 0
ex_overflow  output  1  signed overflow of add/sub
ex_ovf_exc  output  1  overflow exception raised
ex_store_data  output  WIDTH  registered id_store_data
ex_rd  output  REG_AW  registered id_rd
ex_reg_write  output  1  qualified register write
ex_mem_read  output  1  qualified load
ex_mem_write  output  1  qualified store

Behaviour:
- Reset: rst_n low clears every output and internal register to 0 immediately, without waiting for a clock edge. This applies mid-operation too; an in-flight instruction is lost.
- Latency: the combinational ALU result is captured on the next rising edge. Outputs are registered, so the latency is 1 cycle.
- Op encoding:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 110 SUB
  - 111 SLT
  - 100 a & ~b
  - 101 a | ~b
  - 011 reserved; result 0, overflow 0
- Slice carry-in 0 = id_op[2]. Carry into slice k = G[k-1] | (P[k-1] & c[k-1]), produced by the lookahead unit. Slice cout outputs are not used.
- Overflow: taken from the MSB slice. It is meaningful only for ops 010 and 110 and is forced to 0 for all other ops.
- SLT: result = {WIDTH-1 zeros, set_msb ^ overflow_msb}, where set_msb is the raw sign bit from the MSB slice. The correction for overflow is applied in this stage.
- ex_zero is computed from the final muxed result, so it reflects the SLT and reserved-op results.
- Register update priority, evaluated each rising edge with rst_n high:
  1. ex_flush = 1: ex_valid <= 0 and all qualified controls <= 0, even if ex_stall = 1.
  2. else ex_stall = 1: all registers hold.
  3. else: capture all fields; ex_valid <= id_valid.
- Trap: exc = id_valid & id_trap_ovf & overflow.
  - When exc is set, ex_ovf_exc <= 1 and ex_reg_write, ex_mem_read and ex_mem_write <= 0.
  - ex_result and ex_overflow still capture their values for debug.
- Qualification: ex_reg_write, ex_mem_read, ex_mem_write and ex_ovf_exc are ANDed with id_valid at capture. Invalid bubbles can never write state.
- When id_valid = 0 the data fields are captured as-is (don't-care downstream). ex_zero and ex_overflow follow those data fields.
- Simultaneous stall and flush resolve to flush, per the priority above.

Decomposition:
- Shared package, alu_defs: op code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_ANDN, ALU_ORN) and the slice width constant 4.
- One sub-module, cla_carry_unit: inputs G/P vectors of WIDTH/4 bits and c0; output per-slice carry-ins. It is purely combinational and instantiated once.
- The FourBitALU slices are instantiated with a generate loop inside ex_alu_stage.

Test Plan:
- ADD, id_a=0x7FFFFFFF, id_b=0x00000001, id_trap_ovf=1, id_reg_write=1 -> next cycle ex_result=0x80000000, ex_overflow=1, ex_ovf_exc=1, ex_reg_write=0, ex_valid=1.
- SLT, id_a=0xFFFFFFFB (-5), id_b=0x00000003 -> ex_result=1. Then id_a=0x80000000, id_b=0x7FFFFFFF -> ex_result=1 (overflow-corrected). Swapped operands -> ex_result=0, ex_zero=1.
- SUB, id_a=id_b=0x12345678 -> ex_result=0, ex_zero=1, ex_overflow=0. Also ADD 0xFFFFFFFF+1 -> ex_result=0, ex_overflow=0, exercising the full carry chain across all slices.
- Hold AND result 0x0F0F0000 in the register, then assert ex_stall for 3 cycles while changing inputs -> outputs unchanged. Release stall -> new value captured the following edge.
- Assert ex_flush with ex_stall=1 and a live store -> ex_valid=0, ex_mem_write=0 next edge.
- Pulse rst_n low between clock edges while ex_valid=1 -> all outputs 0 immediately, before any clock edge. After release, the first capture occurs on the next rising edge.
